flash_read_scheduler: RTL and testbench

FLASH_READ_SCHEDULER -- requirements
Module: flash_read_scheduler

---
 rtl/flash_ctrl_pkg.sv | 28 ++
 rtl/flash_read_scheduler_if.sv | 36 +++
 rtl/flash_chunk_calc.sv | 22 ++
 rtl/flash_read_scheduler.sv | 153 +++++++++++++++
 tb/tb_flash_read_scheduler.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared constants, state encoding and opcode helper for the flash read path.
package flash_ctrl_pkg;

  localparam logic [7:0]  OP_READ_SINGLE = 8'h03;
  localparam logic [7:0]  OP_READ_DUAL   = 8'h3B;
  localparam logic [7:0]  OP_READ_QUAD   = 8'h6B;
  localparam logic [7:0]  OP_DIE_SEL     = 8'hC2;
  localparam logic [32:0] DIE_SIZE       = 33'h0_0200_0000;
  localparam int          MAX_CHUNK      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIE_SEL,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_FINISH
  } sched_state_t;

  function automatic logic [7:0] read_opcode(input logic [1:0] mode);
    case (mode)
      2'b01:   return OP_READ_DUAL;
      2'b10:   return OP_READ_QUAD;
      default: return OP_READ_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/flash_read_scheduler_if.sv
// Job intake, command issue and status signals of the flash read scheduler.
interface flash_read_scheduler_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_start_addr;
  logic [31:0] job_end_addr;
  logic [1:0]  job_mode;
  logic        job_die_switch_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [1:0]  cmd_mode;
  logic        cmd_done;
  logic [5:0]  fifo_free;
  logic        job_busy;
  logic        job_done;
  logic        job_err;
  logic [6:0]  cur_die;

  // The scheduler masters the command bus and serves the job port.
  modport master (
    input  job_valid, job_start_addr, job_end_addr, job_mode, job_die_switch_en,
    input  cmd_ready, cmd_done, fifo_free,
    output job_ready, cmd_valid, cmd_opcode, cmd_addr, cmd_len, cmd_mode,
    output job_busy, job_done, job_err, cur_die
  );

  modport slave (
    output job_valid, job_start_addr, job_end_addr, job_mode, job_die_switch_en,
    output cmd_ready, cmd_done, fifo_free,
    input  job_ready, cmd_valid, cmd_opcode, cmd_addr, cmd_len, cmd_mode,
    input  job_busy, job_done, job_err, cur_die
  );
endinterface

// File: rtl/flash_chunk_calc.sv
// Next read chunk length: min(MAX_CHUNK, bytes left in job, bytes left in die).
module flash_chunk_calc
  import flash_ctrl_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic [31:0] end_addr,
  output logic [4:0]  chunk_len
);
  logic [32:0] remaining;
  logic [32:0] to_boundary;
  logic [32:0] limit;

  // 33-bit so an end address of 0xFFFF_FFFF cannot wrap the remaining count.
  always_comb begin
    remaining   = {1'b0, end_addr} - {1'b0, cur_addr} + 33'd1;
    to_boundary = DIE_SIZE - {8'b0, cur_addr[24:0]};
    limit       = 33'(MAX_CHUNK);
    if (remaining < limit)   limit = remaining;
    if (to_boundary < limit) limit = to_boundary;
    chunk_len   = limit[4:0];
  end
endmodule

// File: rtl/flash_read_scheduler.sv
// Splits an address-range read job into die-select and <=16-byte read commands.
module flash_read_scheduler
  import flash_ctrl_pkg::*;
(
  input  logic                  system_clk,
  input  logic                  system_reset,
  flash_read_scheduler_if.master bus
);
  sched_state_t state_reg, state_next;
  logic [32:0]  cur_addr_reg, cur_addr_next;
  logic [31:0]  end_addr_reg, end_addr_next;
  logic [1:0]   mode_reg, mode_next;
  logic         switch_en_reg, switch_en_next;
  logic [6:0]   cur_die_reg, cur_die_next;
  logic         cmd_valid_reg, cmd_valid_next;
  logic [7:0]   cmd_opcode_reg, cmd_opcode_next;
  logic [31:0]  cmd_addr_reg, cmd_addr_next;
  logic [4:0]   cmd_len_reg, cmd_len_next;
  logic [1:0]   cmd_mode_reg, cmd_mode_next;
  logic         sent_reg, sent_next;
  logic         job_err_reg, job_err_next;
  logic [4:0]   chunk_len;
  logic [32:0]  advanced_addr;
  logic [6:0]   addr_die;

  flash_chunk_calc u_chunk_calc (
    .cur_addr  (cur_addr_reg[31:0]),
    .end_addr  (end_addr_reg),
    .chunk_len (chunk_len)
  );

  assign advanced_addr = cur_addr_reg + {28'b0, cmd_len_reg};
  assign addr_die      = cur_addr_reg[31:25];

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    end_addr_next   = end_addr_reg;
    mode_next       = mode_reg;
    switch_en_next  = switch_en_reg;
    cur_die_next    = cur_die_reg;
    cmd_valid_next  = cmd_valid_reg;
    cmd_opcode_next = cmd_opcode_reg;
    cmd_addr_next   = cmd_addr_reg;
    cmd_len_next    = cmd_len_reg;
    cmd_mode_next   = cmd_mode_reg;
    sent_next       = sent_reg;
    job_err_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.job_valid) begin
          cur_addr_next  = {1'b0, bus.job_start_addr};
          end_addr_next  = bus.job_end_addr;
          mode_next      = bus.job_mode;
          switch_en_next = bus.job_die_switch_en;
          state_next     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Later chunks never fail here: cur_addr only re-enters CHECK while <= end.
        if (({1'b0, end_addr_reg} < cur_addr_reg) || (mode_reg == 2'b11)) begin
          job_err_next = 1'b1;
          state_next   = ST_IDLE;
        end else if (switch_en_reg && (addr_die != cur_die_reg)) begin
          cmd_valid_next  = 1'b1;
          cmd_opcode_next = OP_DIE_SEL;
          cmd_addr_next   = {25'b0, addr_die};
          cmd_len_next    = 5'd0;
          cmd_mode_next   = mode_reg;
          sent_next       = 1'b0;
          state_next      = ST_DIE_SEL;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_DIE_SEL: begin
        if (cmd_valid_reg && bus.cmd_ready) begin
          cmd_valid_next = 1'b0;
          sent_next      = 1'b1;
        end
        if (sent_reg && bus.cmd_done) begin
          cur_die_next = addr_die;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!cmd_valid_reg) begin
          if (bus.fifo_free >= {1'b0, chunk_len}) begin
            cmd_valid_next  = 1'b1;
            cmd_opcode_next = read_opcode(mode_reg);
            cmd_addr_next   = cur_addr_reg[31:0];
            cmd_len_next    = chunk_len;
            cmd_mode_next   = mode_reg;
          end
        end else if (bus.cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.cmd_done) begin
          cur_addr_next = advanced_addr;
          state_next    = (advanced_addr > {1'b0, end_addr_reg}) ? ST_FINISH : ST_CHECK;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      state_reg      <= ST_IDLE;
      cur_addr_reg   <= '0;
      end_addr_reg   <= '0;
      mode_reg       <= '0;
      switch_en_reg  <= 1'b0;
      cur_die_reg    <= '0;
      cmd_valid_reg  <= 1'b0;
      cmd_opcode_reg <= '0;
      cmd_addr_reg   <= '0;
      cmd_len_reg    <= '0;
      cmd_mode_reg   <= '0;
      sent_reg       <= 1'b0;
      job_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      end_addr_reg   <= end_addr_next;
      mode_reg       <= mode_next;
      switch_en_reg  <= switch_en_next;
      cur_die_reg    <= cur_die_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_opcode_reg <= cmd_opcode_next;
      cmd_addr_reg   <= cmd_addr_next;
      cmd_len_reg    <= cmd_len_next;
      cmd_mode_reg   <= cmd_mode_next;
      sent_reg       <= sent_next;
      job_err_reg    <= job_err_next;
    end
  end

  assign bus.job_ready  = (state_reg == ST_IDLE);
  assign bus.job_busy   = (state_reg != ST_IDLE);
  assign bus.job_done   = (state_reg == ST_FINISH);
  assign bus.job_err    = job_err_reg;
  assign bus.cur_die    = cur_die_reg;
  assign bus.cmd_valid  = cmd_valid_reg;
  assign bus.cmd_opcode = cmd_opcode_reg;
  assign bus.cmd_addr   = cmd_addr_reg;
  assign bus.cmd_len    = cmd_len_reg;
  assign bus.cmd_mode   = cmd_mode_reg;
endmodule

// File: tb/tb_flash_read_scheduler.sv
// Self-checking bench: directed scenarios plus randomized jobs against a range-splitting model.
module tb_flash_read_scheduler;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [4:0]  len;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   model_die = 0;

  cmd_t obs_q[$];
  cmd_t exp_q[$];
  int   obs_done, obs_err, obs_unstable, obs_fifo_viol, obs_first_valid;
  int   obs_timeout, obs_max_hold, obs_mode_bad;

  flash_read_scheduler_if bus ();

  flash_read_scheduler dut (
    .system_clk   (clk),
    .system_reset (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Reference: walk the byte range, cutting at 16 bytes and at every 32 MiB die edge.
  function automatic void model_job(input logic [31:0] s, input logic [31:0] e,
                                    input logic [1:0] m, input logic sw);
    longint a, el, room, l;
    int     die;
    logic [7:0] opc;
    exp_q.delete();
    if (e < s || m == 2'b11) return;
    opc = (m == 2'b00) ? 8'h03 : (m == 2'b01) ? 8'h3B : 8'h6B;
    a  = s;
    el = e;
    while (a <= el) begin
      die = int'(a / 33554432);
      if (sw && die != model_die) begin
        exp_q.push_back({8'hC2, 32'(die), 5'd0});
        model_die = die;
      end
      room = 33554432 - (a % 33554432);
      l = 16;
      if (el - a + 1 < l) l = el - a + 1;
      if (room < l) l = room;
      exp_q.push_back({opc, 32'(a), 5'(l)});
      a += l;
    end
  endfunction

  // Drives one job and plays the read engine; records what the scheduler emitted.
  task automatic exec_job(input logic [31:0] s, input logic [31:0] e, input logic [1:0] m,
                          input logic sw, input int hold_fixed, input int low_cycles);
    int   cyc, hold_cnt, hold_req, done_cd, tail, k;
    logic pending, prev_valid, rdy;
    logic [5:0] applied_fifo;
    cmd_t last, cur;
    obs_q.delete();
    obs_done = 0; obs_err = 0; obs_unstable = 0; obs_fifo_viol = 0;
    obs_first_valid = -1; obs_timeout = 0; obs_max_hold = 0; obs_mode_bad = 0;
    hold_cnt = 0; done_cd = 0; tail = 0; pending = 0; prev_valid = 0; last = '0;
    hold_req = (hold_fixed >= 0) ? hold_fixed : $urandom_range(0, 3);
    @(negedge clk);
    for (k = 0; k < 20 && bus.job_ready !== 1'b1; k++) @(negedge clk);
    bus.job_start_addr    = s;
    bus.job_end_addr      = e;
    bus.job_mode          = m;
    bus.job_die_switch_en = sw;
    bus.job_valid         = 1'b1;
    applied_fifo = (low_cycles > 0) ? 6'd8 : (low_cycles < 0) ? 6'($urandom_range(0, 32)) : 6'd32;
    bus.fifo_free = applied_fifo;
    @(negedge clk);
    bus.job_valid = 1'b0;
    cyc = 1;
    while (cyc < 3000 && tail < 4) begin
      if (bus.job_done === 1'b1) obs_done++;
      if (bus.job_err === 1'b1) obs_err++;
      cur = {bus.cmd_opcode, bus.cmd_addr, bus.cmd_len};
      bus.cmd_done = (done_cd == 1);
      if (done_cd > 0) done_cd--;
      rdy = 1'b0;
      if (bus.cmd_valid === 1'b1) begin
        if (obs_first_valid < 0) obs_first_valid = cyc;
        if (!prev_valid && cur.op != 8'hC2 && applied_fifo < {1'b0, cur.len}) obs_fifo_viol++;
        if (pending && cur !== last) obs_unstable++;
        if (cur.op != 8'hC2 && bus.cmd_mode !== m) obs_mode_bad++;
        rdy = (hold_cnt >= hold_req);
        if (rdy) begin
          obs_q.push_back(cur);
          done_cd  = $urandom_range(1, 4);
          hold_cnt = 0;
          hold_req = (hold_fixed >= 0) ? hold_fixed : $urandom_range(0, 3);
        end else begin
          hold_cnt++;
          if (hold_cnt > obs_max_hold) obs_max_hold = hold_cnt;
        end
      end else if (pending) begin
        obs_unstable++;
      end
      pending       = (bus.cmd_valid === 1'b1) && !rdy;
      last          = cur;
      prev_valid    = (bus.cmd_valid === 1'b1);
      bus.cmd_ready = rdy;
      applied_fifo  = (low_cycles < 0) ? 6'($urandom_range(0, 32)) : (cyc < low_cycles) ? 6'd8 : 6'd32;
      bus.fifo_free = applied_fifo;
      if (obs_done > 0 || obs_err > 0) tail++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) obs_timeout = 1;
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.fifo_free = 6'd32;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_assert++; if (bus.job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready got %b want 1", bus.job_ready); end
    n_assert++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got %b want 0", bus.cmd_valid); end
    n_assert++; if ({bus.cmd_opcode, bus.cmd_addr, bus.cmd_len, bus.cmd_mode} !== 47'd0) begin
      n_fail++; $display("FAIL reset_cmd_fields got %h/%h/%0d/%0d want 0", bus.cmd_opcode, bus.cmd_addr, bus.cmd_len, bus.cmd_mode); end
    n_assert++; if ({bus.job_busy, bus.job_done, bus.job_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status got %b%b%b want 000", bus.job_busy, bus.job_done, bus.job_err); end
    n_assert++; if (bus.cur_die !== 7'd0) begin n_fail++; $display("FAIL reset_cur_die got %0d want 0", bus.cur_die); end
    model_die = 0;
    $display("reset: ready=%b busy=%b cur_die=%0d", bus.job_ready, bus.job_busy, bus.cur_die);
  endtask

  task automatic test_single();
    cmd_t exp0, exp1;
    exp0 = {8'h03, 32'h0, 5'd16};
    exp1 = {8'h03, 32'h10, 5'd1};
    exec_job(32'h0, 32'h10, 2'b00, 1'b0, 0, 0);
    $display("single: cmds=%0d done=%0d first_valid=%0d", obs_q.size(), obs_done, obs_first_valid);
    n_assert++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL single_count got %0d want 2", obs_q.size()); end
    n_assert++; if (obs_q.size() > 0 && obs_q[0] !== exp0) begin n_fail++; $display("FAIL single_cmd0 got %h want %h", obs_q[0], exp0); end
    n_assert++; if (obs_q.size() > 1 && obs_q[1] !== exp1) begin n_fail++; $display("FAIL single_cmd1 got %h want %h", obs_q[1], exp1); end
    n_assert++; if (obs_done != 1 || obs_err != 0) begin n_fail++; $display("FAIL single_done got done=%0d err=%0d want 1/0", obs_done, obs_err); end
    n_assert++; if (obs_first_valid < 2) begin n_fail++; $display("FAIL single_latency got %0d want >=2", obs_first_valid); end
    n_assert++; if (obs_mode_bad != 0 || obs_timeout != 0) begin n_fail++; $display("FAIL single_mode got bad=%0d timeout=%0d want 0/0", obs_mode_bad, obs_timeout); end
  endtask

  task automatic test_quad_hold();
    cmd_t exp0, exp1;
    exp0 = {8'h6B, 32'h2000, 5'd16};
    exp1 = {8'h6B, 32'h2010, 5'd1};
    exec_job(32'h2000, 32'h2010, 2'b10, 1'b0, 5, 0);
    $display("quad_hold: cmds=%0d max_hold=%0d unstable=%0d", obs_q.size(), obs_max_hold, obs_unstable);
    n_assert++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL quad_count got %0d want 2", obs_q.size()); end
    n_assert++; if (obs_q.size() > 0 && obs_q[0] !== exp0) begin n_fail++; $display("FAIL quad_cmd0 got %h want %h", obs_q[0], exp0); end
    n_assert++; if (obs_q.size() > 1 && obs_q[1] !== exp1) begin n_fail++; $display("FAIL quad_cmd1 got %h want %h", obs_q[1], exp1); end
    n_assert++; if (obs_max_hold != 5) begin n_fail++; $display("FAIL quad_hold_cycles got %0d want 5", obs_max_hold); end
    n_assert++; if (obs_unstable != 0 || obs_mode_bad != 0) begin n_fail++; $display("FAIL quad_stable got unstable=%0d modebad=%0d want 0/0", obs_unstable, obs_mode_bad); end
  endtask

  task automatic test_fifo_backpressure();
    cmd_t exp0;
    exp0 = {8'h03, 32'h4000, 5'd16};
    exec_job(32'h4000, 32'h400F, 2'b00, 1'b0, 0, 20);
    $display("fifo_backpressure: first_valid=%0d viol=%0d cmds=%0d", obs_first_valid, obs_fifo_viol, obs_q.size());
    n_assert++; if (obs_first_valid < 21) begin n_fail++; $display("FAIL fifo_early_valid got cycle %0d want >=21", obs_first_valid); end
    n_assert++; if (obs_fifo_viol != 0) begin n_fail++; $display("FAIL fifo_violation got %0d want 0", obs_fifo_viol); end
    n_assert++; if (obs_q.size() != 1 || obs_q[0] !== exp0) begin
      n_fail++; $display("FAIL fifo_cmd got n=%0d first=%h want 1/%h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, exp0); end
    n_assert++; if (obs_done != 1) begin n_fail++; $display("FAIL fifo_done got %0d want 1", obs_done); end
  endtask

  task automatic test_die_switch();
    cmd_t exp_cmds[4];
    exp_cmds[0] = {8'h03, 32'h01FF_FFF0, 5'd16};
    exp_cmds[1] = {8'hC2, 32'h1, 5'd0};
    exp_cmds[2] = {8'h03, 32'h0200_0000, 5'd16};
    exp_cmds[3] = {8'h03, 32'h0200_0010, 5'd1};
    exec_job(32'h01FF_FFF0, 32'h0200_0010, 2'b00, 1'b1, -1, 0);
    model_die = 1;
    $display("die_switch: cmds=%0d cur_die=%0d done=%0d", obs_q.size(), bus.cur_die, obs_done);
    n_assert++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL die_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (i < obs_q.size() && obs_q[i] !== exp_cmds[i]) begin
        n_fail++; $display("FAIL die_cmd%0d got %h want %h", i, obs_q[i], exp_cmds[i]); end
    end
    n_assert++; if (bus.cur_die !== 7'd1) begin n_fail++; $display("FAIL die_cur_die got %0d want 1", bus.cur_die); end
    n_assert++; if (obs_done != 1 || obs_unstable != 0) begin n_fail++; $display("FAIL die_done got done=%0d unstable=%0d want 1/0", obs_done, obs_unstable); end
  endtask

  task automatic test_errors();
    exec_job(32'h100, 32'h0FF, 2'b00, 1'b0, 0, 0);
    $display("err_range: err=%0d cmds=%0d", obs_err, obs_q.size());
    n_assert++; if (obs_err != 1 || obs_done != 0) begin n_fail++; $display("FAIL err_range got err=%0d done=%0d want 1/0", obs_err, obs_done); end
    n_assert++; if (obs_first_valid != -1) begin n_fail++; $display("FAIL err_range_cmd got valid at %0d want none", obs_first_valid); end
    exec_job(32'h200, 32'h210, 2'b11, 1'b0, 0, 0);
    $display("err_mode: err=%0d cmds=%0d", obs_err, obs_q.size());
    n_assert++; if (obs_err != 1 || obs_done != 0) begin n_fail++; $display("FAIL err_mode got err=%0d done=%0d want 1/0", obs_err, obs_done); end
    n_assert++; if (obs_first_valid != -1) begin n_fail++; $display("FAIL err_mode_cmd got valid at %0d want none", obs_first_valid); end
  endtask

  task automatic test_random();
    logic [31:0] s, e;
    logic [32:0] wide;
    logic [6:0]  die;
    logic [1:0]  m;
    logic        sw;
    bit          is_err;
    int          mism;
    for (int j = 0; j < 16; j++) begin
      die = 7'($urandom_range(0, 127));
      case ($urandom_range(0, 2))
        0:       s = {die, 25'h1FF_FFFF} - 32'($urandom_range(0, 24));
        1:       s = $urandom;
        default: s = {die, 25'h0} + 32'($urandom_range(0, 40));
      endcase
      wide = {1'b0, s} + 33'($urandom_range(0, 56));
      e = wide[32] ? 32'hFFFF_FFFF : wide[31:0];
      if (j == 0) begin s = 32'hFFFF_FFF0; e = 32'hFFFF_FFFF; end
      if (j == 5 && s != 0) e = s - 32'd1;
      m  = (j == 9) ? 2'b11 : 2'($urandom_range(0, 2));
      sw = 1'($urandom_range(0, 1));
      is_err = (e < s) || (m == 2'b11);
      model_job(s, e, m, sw);
      exec_job(s, e, m, sw, -1, -1);
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) mism++;
      $display("random %0d: %h..%h mode=%0d sw=%0d cmds=%0d/%0d die=%0d", j, s, e, m, sw, obs_q.size(), exp_q.size(), bus.cur_die);
      n_assert++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count got %0d want %0d", j, obs_q.size(), exp_q.size()); end
      n_assert++; if (mism != 0) begin n_fail++; $display("FAIL rnd%0d_cmds got %0d mismatching commands want 0", j, mism); end
      n_assert++; if (obs_done != (is_err ? 0 : 1) || obs_err != (is_err ? 1 : 0)) begin
        n_fail++; $display("FAIL rnd%0d_status got done=%0d err=%0d want %0d/%0d", j, obs_done, obs_err, !is_err, is_err); end
      n_assert++; if (obs_unstable != 0 || obs_fifo_viol != 0 || obs_mode_bad != 0 || obs_timeout != 0) begin
        n_fail++; $display("FAIL rnd%0d_protocol got unstable=%0d fifo=%0d mode=%0d timeout=%0d want 0", j, obs_unstable, obs_fifo_viol, obs_mode_bad, obs_timeout); end
      n_assert++; if (bus.cur_die !== 7'(model_die)) begin n_fail++; $display("FAIL rnd%0d_cur_die got %0d want %0d", j, bus.cur_die, model_die); end
    end
  endtask

  task automatic test_reset_mid_job();
    int bad;
    bit seen;
    @(negedge clk);
    bus.job_start_addr = 32'h5000; bus.job_end_addr = 32'h503F; bus.job_mode = 2'b00;
    bus.job_die_switch_en = 1'b0; bus.fifo_free = 6'd32; bus.cmd_ready = 1'b1; bus.job_valid = 1'b1;
    @(negedge clk);
    bus.job_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) seen = 1;
    end
    n_assert++; if (!seen) begin n_fail++; $display("FAIL rstmid_issue got no cmd_valid want one within 20 cycles"); end
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    n_assert++; if (bus.job_busy !== 1'b1 || bus.cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wait got busy=%b valid=%b want 1/0", bus.job_busy, bus.cmd_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_die = 0;
    $display("reset_mid_job: ready=%b busy=%b valid=%b", bus.job_ready, bus.job_busy, bus.cmd_valid);
    n_assert++; if (bus.cmd_valid !== 1'b0 || bus.job_busy !== 1'b0 || bus.job_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_idle got valid=%b busy=%b ready=%b want 0/0/1", bus.cmd_valid, bus.job_busy, bus.job_ready); end
    bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.cmd_valid !== 1'b0 || bus.job_busy !== 1'b0 || bus.job_done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_stale_done got %0d active cycles want 0", bad); end
    n_assert++; if (bus.cur_die !== 7'd0) begin n_fail++; $display("FAIL rstmid_cur_die got %0d want 0", bus.cur_die); end
  endtask

  initial begin
    bus.job_valid = 1'b0; bus.job_start_addr = '0; bus.job_end_addr = '0; bus.job_mode = '0;
    bus.job_die_switch_en = 1'b0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.fifo_free = 6'd32;
    test_reset();
    test_single();
    test_quad_hold();
    test_fifo_backpressure();
    test_die_switch();
    test_errors();
    test_random();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
